sparsity_flag_gen: RTL and testbench

Upstream producer for the sparsity skip stage. Consumes a stream of input-feature-map pixels for one frame (NUM_BLOCK blocks of BLOCK_WIDTH pixels), writes a 1-bit nonzero flag per pixel into the flag RAM, and builds the per-block `valid` mask and nonzero count. The downstream skip logic reads the mask and the RAM flags to decide which blocks to jump over. The mask is handed over with a valid/ready handshake.

---
 rtl/sparsity_flag_gen_if.sv | 33 +++
 rtl/sparsity_flag_gen.sv | 110 +++++++++++
 tb/tb_sparsity_flag_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sparsity_flag_gen_if.sv
// Handshake and result bus between the pixel producer, the flag RAM writer and the skip stage.
// The master side drives the pixels and mask_ready. The slave side is the flag generator.
interface sparsity_flag_gen_if #(
  parameter int PIX_WIDTH  = 8,
  parameter int NUM_BLOCK  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  start;
  logic                  in_valid;
  logic [PIX_WIDTH-1:0]  in_data;
  logic                  in_ready;
  logic                  flag_wr_req;
  logic [ADDR_WIDTH-1:0] flag_wr_addr;
  logic                  flag_wr_data;
  logic                  mask_valid;
  logic                  mask_ready;
  logic [NUM_BLOCK-1:0]  valid;
  logic [CNT_WIDTH-1:0]  nz_count;
  logic                  busy;

  modport master (
    output start, in_valid, in_data, mask_ready,
    input  in_ready, flag_wr_req, flag_wr_addr, flag_wr_data,
           mask_valid, valid, nz_count, busy
  );

  modport slave (
    input  start, in_valid, in_data, mask_ready,
    output in_ready, flag_wr_req, flag_wr_addr, flag_wr_data,
           mask_valid, valid, nz_count, busy
  );
endinterface

// File: rtl/sparsity_flag_gen.sv
// Per-pixel nonzero flag writer and per-block valid mask / nonzero count builder for one frame.
//   state     | meaning
//   S_IDLE    | waiting for start; last frame's mask and count still visible
//   S_COLLECT | accepting pixels, one flag RAM write per accepted pixel
//   S_HOLD    | frame result offered with mask_valid until mask_ready
module sparsity_flag_gen #(
  parameter int PIX_WIDTH   = 8,
  parameter int BLOCK_WIDTH = 10,
  parameter int NUM_BLOCK   = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  sparsity_flag_gen_if.slave   bus
);
  localparam int PIX_IDX_W = (BLOCK_WIDTH > 1) ? $clog2(BLOCK_WIDTH) : 1;
  localparam int BLK_IDX_W = (NUM_BLOCK > 1) ? $clog2(NUM_BLOCK) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]            state;
  logic [PIX_IDX_W-1:0]  pix_idx;
  logic [BLK_IDX_W-1:0]  blk_idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [NUM_BLOCK-1:0]  valid_q;
  logic [CNT_WIDTH-1:0]  nz_q;
  logic                  wr_req_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  wr_data_q;

  logic accept, flag, last_pix, last_blk;

  assign accept   = (state == S_COLLECT) && bus.in_valid;
  assign flag     = |bus.in_data;
  assign last_pix = (pix_idx == PIX_IDX_W'(BLOCK_WIDTH - 1));
  assign last_blk = (blk_idx == BLK_IDX_W'(NUM_BLOCK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pix_idx   <= '0;
      blk_idx   <= '0;
      addr      <= '0;
      valid_q   <= '0;
      nz_q      <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
    end else if (clr) begin
      // clr wins over a same-cycle start or accept: the frame is dropped with no write
      state     <= S_IDLE;
      pix_idx   <= '0;
      blk_idx   <= '0;
      addr      <= '0;
      valid_q   <= '0;
      nz_q      <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
    end else begin
      wr_req_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_COLLECT;
            pix_idx <= '0;
            blk_idx <= '0;
            addr    <= '0;
            valid_q <= '0;
            nz_q    <= '0;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            wr_req_q         <= 1'b1;
            wr_addr_q        <= addr;
            wr_data_q        <= flag;
            valid_q[blk_idx] <= valid_q[blk_idx] | flag;
            nz_q             <= nz_q + CNT_WIDTH'(flag);
            addr             <= addr + ADDR_WIDTH'(1);
            if (last_pix) begin
              pix_idx <= '0;
              blk_idx <= blk_idx + BLK_IDX_W'(1);
              if (last_blk) state <= S_HOLD;
            end else begin
              pix_idx <= pix_idx + PIX_IDX_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (bus.mask_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == S_COLLECT);
  assign bus.mask_valid   = (state == S_HOLD);
  assign bus.busy         = (state != S_IDLE);
  assign bus.flag_wr_req  = wr_req_q;
  assign bus.flag_wr_addr = wr_addr_q;
  assign bus.flag_wr_data = wr_data_q;
  assign bus.valid        = valid_q;
  assign bus.nz_count     = nz_q;
endmodule

// File: tb/tb_sparsity_flag_gen.sv
// Randomized and directed bench for sparsity_flag_gen against a frame-level model built from pixel arrays.
module tb_sparsity_flag_gen;
  localparam int NB   = 16;
  localparam int BW   = 10;
  localparam int NPIX = NB * BW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  sparsity_flag_gen_if bus ();

  sparsity_flag_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;
  int wr_seen = 0;

  logic [7:0] frame_px [NPIX];

  // model: the frame so far as an array of flags plus where the producer is in the frame
  int   m_phase = 0;
  int   m_cnt   = 0;
  bit   m_pix [NPIX];
  bit   m_wr_req  = 1'b0;
  int   m_wr_addr = 0;
  bit   m_wr_data = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NB-1:0] exp_valid();
    logic [NB-1:0] v = '0;
    for (int b = 0; b < NB; b++)
      for (int p = 0; p < BW; p++)
        if ((b * BW + p) < m_cnt && m_pix[b * BW + p]) v[b] = 1'b1;
    return v;
  endfunction

  function automatic int exp_nz();
    int n = 0;
    for (int i = 0; i < m_cnt; i++) n += int'(m_pix[i]);
    return n;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || clr) begin
      m_phase = 0; m_cnt = 0;
      m_wr_req = 1'b0; m_wr_addr = 0; m_wr_data = 1'b0;
    end else begin
      m_wr_req = 1'b0;
      if (m_phase == 0) begin
        if (bus.start) begin m_phase = 1; m_cnt = 0; end
      end else if (m_phase == 1) begin
        if (bus.in_valid) begin
          m_pix[m_cnt] = (bus.in_data != 8'd0);
          m_wr_req  = 1'b1;
          m_wr_addr = m_cnt;
          m_wr_data = m_pix[m_cnt];
          m_cnt++;
          if (m_cnt == NPIX) m_phase = 2;
        end
      end else begin
        if (bus.mask_ready) m_phase = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.flag_wr_req === 1'b1) wr_seen++;
    if (chk_en) begin
      chk("in_ready",   32'(bus.in_ready),     32'(m_phase == 1));
      chk("mask_valid", 32'(bus.mask_valid),   32'(m_phase == 2));
      chk("busy",       32'(bus.busy),         32'(m_phase != 0));
      chk("wr_req",     32'(bus.flag_wr_req),  32'(m_wr_req));
      chk("wr_addr",    32'(bus.flag_wr_addr), 32'(m_wr_addr));
      chk("wr_data",    32'(bus.flag_wr_data), 32'(m_wr_data));
      chk("valid",      32'(bus.valid),        32'(exp_valid()));
      chk("nz_count",   32'(bus.nz_count),     32'(exp_nz()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++)
      frame_px[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
  endtask

  task automatic fill_zero();
    for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd0;
  endtask

  task automatic run_frame(input int gap_mode, input int hold, input bit pulse_start,
                           input bit first_lit, input bit noise, input bit do_lit,
                           input logic [NB-1:0] lit_valid, input int lit_nz);
    int base, gaps;
    if (noise) begin
      bus.in_valid = 1'b1; bus.in_data = 8'($urandom_range(1, 255));
      tick();
    end
    base = wr_seen;
    bus.in_valid = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      gaps = (gap_mode == 1) ? ((i > 0) ? 1 : 0) : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
        tick();
      end
      bus.in_valid = 1'b1; bus.in_data = frame_px[i];
      tick();
      if (i == 0 && first_lit) begin
        @(negedge clk);
        chk("first_wr_req", 32'(bus.flag_wr_req), 32'd1);
        chk("first_wr_addr", 32'(bus.flag_wr_addr), 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    if (do_lit) begin
      chk("lit_mask_valid", 32'(bus.mask_valid), 32'd1);
      chk("lit_valid", 32'(bus.valid), 32'(lit_valid));
      chk("lit_nz", 32'(bus.nz_count), 32'(lit_nz));
      chk("lit_writes", 32'(wr_seen - base), 32'(NPIX));
    end
    for (int k = 0; k < hold; k++) begin
      bus.start = pulse_start && (k == 1);
      bus.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_data = 8'($urandom_range(1, 255));
      tick();
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.mask_ready = 1'b1;
    tick();
    bus.mask_ready = 1'b0;
    @(negedge clk);
    if (do_lit) chk("lit_idle_after_ready", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int base;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.mask_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_nz", 32'(bus.nz_count), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    fill_zero();
    run_frame(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 0);

    fill_zero();
    frame_px[13] = 8'h05;
    run_frame(0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1);

    fill_zero();
    frame_px[0] = 8'h01; frame_px[9] = 8'h80; frame_px[10] = 8'h3c; frame_px[159] = 8'hff;
    run_frame(1, 5, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8003, 4);

    for (int f = 0; f < 4; f++) begin
      fill_random();
      run_frame(2, int'($urandom_range(0, 4)), 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0);
    end

    // reset mid-frame after 50 accepts
    fill_random();
    frame_px[4] = 8'h22;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus.in_valid = 1'b1; bus.in_data = frame_px[i];
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_wr_req", 32'(bus.flag_wr_req), 32'd0);
    chk("arst_wr_addr", 32'(bus.flag_wr_addr), 32'd0);
    chk("arst_wr_data", 32'(bus.flag_wr_data), 32'd0);
    chk("arst_mask_valid", 32'(bus.mask_valid), 32'd0);
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_nz", 32'(bus.nz_count), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fill_random();
    run_frame(2, 2, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0);

    // clr together with the accept of pixel 20
    fill_random();
    frame_px[3] = 8'h11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    base = wr_seen;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1; bus.in_data = frame_px[i];
      tick();
    end
    bus.in_valid = 1'b1; bus.in_data = 8'hff; clr = 1'b1;
    tick();
    clr = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_no_write", 32'(bus.flag_wr_req), 32'd0);
    chk("clr_busy", 32'(bus.busy), 32'd0);
    chk("clr_valid", 32'(bus.valid), 32'd0);
    chk("clr_writes", 32'(wr_seen - base), 32'd20);

    // clr outranks start in IDLE
    bus.start = 1'b1; clr = 1'b1;
    tick();
    bus.start = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("clr_over_start", 32'(bus.busy), 32'd0);
    tick();

    fill_random();
    run_frame(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
